// File: rtl/ksw_row_zdrop_if.sv
// Row handshake between the ksw controller / H-update stage (master) and
// the row reduction + z-drop block (slave).
interface ksw_row_zdrop_if #(
    parameter int HW = 32,
    parameter int IW = 16
);
    logic                 row_start;
    logic signed [IW-1:0] r;
    logic signed [IW-1:0] st;
    logic signed [IW-1:0] en;
    logic                 h_valid;
    logic signed [HW-1:0] h_data;
    logic                 h_ready;
    logic                 busy;
    logic                 row_done;
    logic signed [HW-1:0] max_h;
    logic signed [IW-1:0] max_t;
    logic signed [IW-1:0] max_q;
    logic                 zdropped;

    modport master (
        output row_start, r, st, en, h_valid, h_data,
        input  h_ready, busy, row_done, max_h, max_t, max_q, zdropped
    );

    modport slave (
        input  row_start, r, st, en, h_valid, h_data,
        output h_ready, busy, row_done, max_h, max_t, max_q, zdropped
    );
endinterface

// File: rtl/ksw_row_zdrop.sv
// Per-anti-diagonal row max reduction, global-best update and z-drop termination.
// Optional macro KSW_ZDROP_BAND_EN adds a band-width termination check (parameter BAND).
module ksw_row_zdrop #(
    parameter int HW    = 32,
    parameter int IW    = 16,
    parameter int ZDROP = 400,
`ifdef KSW_ZDROP_BAND_EN
    parameter int BAND  = 500,
`endif
    parameter int GAPE  = 2
) (
    input logic            clk,
    input logic            rst,
    ksw_row_zdrop_if.slave bus
);
    localparam int WW = HW + IW;
    localparam logic signed [WW-1:0] ZD_W = WW'(ZDROP);
    localparam logic signed [WW-1:0] GE_W = WW'(GAPE);

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, DROPPED} state_t;
    state_t state;

    logic signed [IW-1:0] r_q;
    logic signed [IW-1:0] en_q;
    logic signed [IW-1:0] t_cnt;
    logic signed [IW-1:0] row_t;
    logic signed [HW-1:0] row_max;

    logic signed [IW-1:0] q_cand;
    logic signed [WW-1:0] tl, ql, dl, l, diff, lim;
    logic                 better, in_cone, drop;

    // Decision datapath, widened to HW+IW bits so neither the length nor the score gap can wrap.
    always_comb begin
        q_cand  = r_q - row_t;
        tl      = WW'(row_t) - WW'(bus.max_t);
        ql      = WW'(q_cand) - WW'(bus.max_q);
        dl      = tl - ql;
        l       = dl[WW-1] ? -dl : dl;
        diff    = WW'(bus.max_h) - WW'(row_max);
        lim     = ZD_W + l * GE_W;
        better  = row_max > bus.max_h;
        in_cone = (row_t >= bus.max_t) && (q_cand >= bus.max_q);
        drop    = in_cone && (ZDROP >= 0) && (diff > lim);
`ifdef KSW_ZDROP_BAND_EN
        if (in_cone && (l > WW'(2 * BAND))) drop = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            r_q          <= '0;
            en_q         <= '0;
            t_cnt        <= '0;
            row_t        <= '0;
            row_max      <= '0;
            bus.h_ready  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.row_done <= 1'b0;
            bus.max_h    <= '0;
            bus.max_t    <= '1;
            bus.max_q    <= '1;
            bus.zdropped <= 1'b0;
        end else begin
            bus.row_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the previous row_done is dropped on purpose.
                    if (bus.row_start && !bus.row_done && (bus.en >= bus.st)) begin
                        r_q         <= bus.r;
                        en_q        <= bus.en;
                        t_cnt       <= bus.st;
                        row_max     <= {1'b1, {(HW-1){1'b0}}};
                        bus.h_ready <= 1'b1;
                        bus.busy    <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.h_valid) begin
                        if (bus.h_data > row_max) begin
                            row_max <= bus.h_data;
                            row_t   <= t_cnt;
                        end
                        if (t_cnt == en_q) begin
                            bus.h_ready <= 1'b0;
                            state       <= DECIDE;
                        end else begin
                            t_cnt <= t_cnt + 1'b1;
                        end
                    end
                end
                DECIDE: begin
                    bus.busy     <= 1'b0;
                    bus.row_done <= 1'b1;
                    if (better) begin
                        bus.max_h <= row_max;
                        bus.max_t <= row_t;
                        bus.max_q <= q_cand;
                        state     <= IDLE;
                    end else if (drop) begin
                        bus.zdropped <= 1'b1;
                        state        <= DROPPED;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.h_ready <= 1'b0;
                    bus.busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ksw_row_zdrop.sv
// Randomized bench for ksw_row_zdrop against a row-level behavioural model.
`timescale 1ns/1ps
module tb_ksw_row_zdrop;
    localparam int HW = 32;
    localparam int IW = 16;
    localparam int ZD = 40;
    localparam int GE = 2;
`ifdef KSW_ZDROP_BAND_EN
    localparam int BANDV = 500;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ksw_row_zdrop_if #(.HW(HW), .IW(IW)) bus ();
    ksw_row_zdrop #(.HW(HW), .IW(IW), .ZDROP(ZD), .GAPE(GE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Model state: what must be visible on the outputs after the latest edge.
    logic exp_h_ready, exp_busy, exp_row_done, exp_zd;
    int   exp_max_h, exp_max_t, exp_max_q;
    int   row_h[$];
    bit   vpat[$];

    int n_cmp = 0;
    int n_bad = 0;
    int pin_seq = 0;
    int pin_seen = 0;
    string pin_name;
    int pin_h, pin_t, pin_q, pin_zd;

    task automatic check(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        check("h_ready",  longint'(bus.h_ready),  longint'(exp_h_ready));
        check("busy",     longint'(bus.busy),     longint'(exp_busy));
        check("row_done", longint'(bus.row_done), longint'(exp_row_done));
        check("zdropped", longint'(bus.zdropped), longint'(exp_zd));
        check("max_h",    longint'(bus.max_h),    longint'(exp_max_h));
        check("max_t",    longint'(bus.max_t),    longint'(exp_max_t));
        check("max_q",    longint'(bus.max_q),    longint'(exp_max_q));
        if (pin_seq != pin_seen) begin
            check({pin_name, "_max_h"}, longint'(bus.max_h), longint'(pin_h));
            check({pin_name, "_max_t"}, longint'(bus.max_t), longint'(pin_t));
            check({pin_name, "_max_q"}, longint'(bus.max_q), longint'(pin_q));
            check({pin_name, "_zd"},    longint'(bus.zdropped), longint'(pin_zd));
            pin_seen = pin_seq;
        end
    end

    function automatic int s16(input int x);
        return int'(shortint'(x));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        exp_row_done = 1'b0;
    endtask

    task automatic pin(input string name, input int h, input int t, input int q, input int zd);
        pin_name = name; pin_h = h; pin_t = t; pin_q = q; pin_zd = zd;
        pin_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic set_reset_model();
        exp_h_ready = 0; exp_busy = 0; exp_row_done = 0; exp_zd = 0;
        exp_max_h = 0; exp_max_t = -1; exp_max_q = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.row_start = 0; bus.h_valid = 0;
        set_reset_model();
        step();
        step();
        rst = 1'b0;
    endtask

    // Row-level rules: earliest strict maximum, then global update or z-drop test.
    task automatic commit(input int r, input int st);
        int best, bt, q, tl, ql, l;
        best = row_h[0];
        bt   = st;
        foreach (row_h[i]) if (row_h[i] > best) begin best = row_h[i]; bt = st + i; end
        bt = s16(bt);
        q  = s16(r - bt);
        if (best > exp_max_h) begin
            exp_max_h = best; exp_max_t = bt; exp_max_q = q;
        end else if (bt >= exp_max_t && q >= exp_max_q) begin
            tl = bt - exp_max_t;
            ql = q - exp_max_q;
            l  = (tl - ql < 0) ? ql - tl : tl - ql;
            if (ZD >= 0 && (longint'(exp_max_h) - best) > longint'(ZD) + longint'(l) * GE) exp_zd = 1;
`ifdef KSW_ZDROP_BAND_EN
            if (l > 2 * BANDV) exp_zd = 1;
`endif
        end
    endtask

    task automatic do_row(input int r, input int st, input int en);
        bit acc, v;
        int k, pi;
        bus.row_start = 1; bus.r = r[IW-1:0]; bus.st = st[IW-1:0]; bus.en = en[IW-1:0];
        acc = !exp_zd && !exp_row_done && !exp_busy && (en >= st);
        step();
        bus.row_start = 0;
        if (!acc) return;
        exp_h_ready = 1; exp_busy = 1;
        k = 0; pi = 0;
        while (k <= en - st) begin
            v = (pi < vpat.size()) ? vpat[pi] : ($urandom_range(0, 3) != 0);
            pi++;
            bus.h_valid = v;
            bus.h_data  = v ? row_h[k] : $urandom;
            step();
            if (v) begin
                k++;
                if (k > en - st) exp_h_ready = 0;
            end
        end
        bus.h_valid = 0;
        step();
        exp_busy = 0; exp_row_done = 1;
        commit(r, st);
    endtask

    initial begin
        rst = 1'b0;
        bus.row_start = 0; bus.r = '0; bus.st = '0; bus.en = '0;
        bus.h_valid = 0; bus.h_data = '0;
        set_reset_model();
        #1;
        do_reset();
        pin("reset", 0, -1, -1, 0);

        row_h = '{5}; vpat.delete();
        do_row(0, 0, 0);
        pin("row0", 5, 0, 0, 0);
        step();

        row_h = '{7, 9, 9};
        do_row(4, 1, 3);
        pin("tie", 9, 2, 2, 0);
        step();

        row_h = '{1, 2, 3}; vpat = '{1, 0, 0, 1, 1};
        do_row(6, 3, 5);
        vpat.delete();
        pin("gaps", 9, 2, 2, 0);
        do_row(7, 0, 0);          // lands on the row_done cycle
        step();
        do_row(8, 5, 4);          // en < st
        step(); step();

        do_reset();
        row_h = '{100};
        do_row(20, 10, 10);
        pin("seed", 100, 10, 10, 0);
        step();
        row_h = '{70};
        do_row(30, 16, 16);
        pin("nodrop", 100, 10, 10, 0);
        step();
        row_h = '{50};
        do_row(30, 9, 9);
        pin("outside", 100, 10, 10, 0);
        step();
        row_h = '{10, 20, 50, 50, 3};
        do_row(30, 14, 18);
        pin("drop", 100, 10, 10, 1);
        step();
        row_h = '{500};
        do_row(31, 0, 0);
        step(); step();

        do_reset();
        bus.row_start = 1; bus.r = 16'sd5; bus.st = 16'sd0; bus.en = 16'sd3;
        step();
        bus.row_start = 0;
        exp_h_ready = 1; exp_busy = 1;
        for (int i = 0; i < 2; i++) begin
            bus.h_valid = 1; bus.h_data = 32'sd77;
            step();
        end
        #2;
        do_reset();
        pin("midrst", 0, -1, -1, 0);
        row_h = '{-3, -8};
        do_row(0, 0, 1);
        step();
        row_h = '{12, 4};
        do_row(2, 0, 1);
        pin("clean", 12, 0, 2, 0);
        step();

        for (int n = 0; n < 80; n++) begin
            int st, len, r;
            st  = $urandom_range(0, 40);
            len = $urandom_range(0, 6);
            r   = st + len + $urandom_range(0, 30);
            row_h.delete();
            for (int i = 0; i <= len; i++) row_h.push_back(int'($urandom_range(0, 200)) - 60);
            if ($urandom_range(0, 9) == 0) do_row(r, st + len + 1, st);
            else do_row(r, st, st + len);
            if ($urandom_range(0, 3) != 0) step();
            if (exp_zd) begin
                do_row(r + 1, 0, 1);
                step(); step();
                do_reset();
            end
        end

        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
